e1of2_channel_source: RTL and testbench

- Clocked Verilog-side transmitter for a four-phase, dual-rail (e1of2 per bit), active-high-enable asynchronous channel.
- Accepts words on a synchronous valid/ready interface and buffers them in a small FIFO.
- Drives each word onto WIDTH rail pairs toward a prsim-simulated sink, sequencing on the sink's enable.
- Used in co-simulation benches as the clocked counterpart that feeds a prsim channel sink.

---
 rtl/e1of2_channel_source.sv | 135 +++++++++++++
 tb/tb_e1of2_channel_source.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e1of2_channel_source.sv
// Clocked transmitter for a four-phase, dual-rail (e1of2 per bit) channel with an
// active-high sink enable; words arrive on valid/ready and queue in a small FIFO.
module e1of2_channel_source #(
   parameter int WIDTH       = 1,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic [WIDTH-1:0]       ch_d0,
   output logic [WIDTH-1:0]       ch_d1,
   input  logic                   ch_e,
   output logic [$clog2(DEPTH):0] count,
   output logic [15:0]            tokens_sent,
   output logic                   busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      WAIT_EN_LO,
      NEUTRAL,
      WAIT_EN_HI
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] e_sync;
   logic                   e_s;
   logic [WIDTH-1:0]       mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic                   ready_en;
   logic                   can_send;
   logic                   push;
   logic                   pop;
   logic [WIDTH-1:0]       tx;
   logic [15:0]            token_cnt;

   // ch_e is asynchronous to clk; only the last synchronizer stage is ever used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_sync <= '0;
      end else begin
         // NOTE: clocked state always uses <= so every flop samples pre-edge values.
         e_sync <= {e_sync[SYNC_STAGES-2:0], ch_e};
      end
   end

   assign e_s = e_sync[SYNC_STAGES-1];

   // in_ready stays low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   assign in_ready = ready_en && (count < FULL_COUNT);
   assign push     = in_valid && in_ready;
   assign can_send = (count != '0) && e_s;
   assign pop      = (state == IDLE) && can_send;

   // NOTE: the storage array is not reset; pointers and count decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Rails move only on the edges leaving DATA and NEUTRAL, all bits together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx        <= '0;
         ch_d0     <= '0;
         ch_d1     <= '0;
         token_cnt <= '0;
      end else begin
         if (pop) tx <= mem[rd_ptr];
         if (state == DATA) begin
            ch_d1 <= tx;
            ch_d0 <= ~tx;
         end
         if (state == NEUTRAL) begin
            ch_d1     <= '0;
            ch_d0     <= '0;
            token_cnt <= token_cnt + 16'd1;
         end
      end
   end

   assign tokens_sent = token_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:       if (can_send) state_nxt = DATA;
         DATA:       state_nxt = WAIT_EN_LO;
         WAIT_EN_LO: if (!e_s) state_nxt = NEUTRAL;
         NEUTRAL:    state_nxt = WAIT_EN_HI;
         WAIT_EN_HI: if (e_s) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_e1of2_channel_source.sv
// Directed-plus-random bench: a behavioural four-phase sink, a word scoreboard and
// per-cycle rail protocol checks around e1of2_channel_source.
module tb_e1of2_channel_source;

   localparam int W = 4;
   localparam int D = 4;
   localparam int S = 2;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [W-1:0]  ch_d0;
   logic [W-1:0]  ch_d1;
   logic          ch_e;
   logic [2:0]    count;
   logic [15:0]   tokens_sent;
   logic          busy;

   int            checks = 0;
   int            errors = 0;

   // Sink controls and model state.
   bit            sink_rst   = 1'b1;
   bit            hold_lo    = 1'b0;
   int            sink_delay = 0;
   int            sink_cnt   = 0;
   logic [W-1:0]  exp_q[$];
   logic [15:0]   exp_done   = '0;
   logic [15:0]   tok_adj    = '0;
   bit            prev_valid = 1'b0;
   bit            seen_e_hi  = 1'b1;
   bit            seen_e_lo  = 1'b0;

   e1of2_channel_source #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .ch_d0       (ch_d0),
      .ch_d1       (ch_d1),
      .ch_e        (ch_e),
      .count       (count),
      .tokens_sent (tokens_sent),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Four-phase sink: drop enable some cycles after data, raise it after neutral.
   initial begin
      ch_e = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (sink_rst) begin
            ch_e = 1'b1;
            sink_cnt = 0;
         end else if (hold_lo) begin
            ch_e = 1'b0;
            sink_cnt = 0;
         end else if (ch_e && ((ch_d0 | ch_d1) != '0)) begin
            if (sink_cnt >= sink_delay) begin
               ch_e = 1'b0;
               sink_cnt = 0;
            end else sink_cnt++;
         end else if (!ch_e && ((ch_d0 | ch_d1) == '0)) begin
            if (sink_cnt >= sink_delay) begin
               ch_e = 1'b1;
               sink_cnt = 0;
            end else sink_cnt++;
         end
      end
   end

   // Protocol monitor and scoreboard, sampled on the falling edge.
   initial begin
      logic         valid_now;
      logic         together;
      logic [W-1:0] w;
      logic [W-1:0] wn;
      logic [15:0]  tok_exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_done   = '0;
            prev_valid = 1'b0;
            seen_e_hi  = 1'b1;
            seen_e_lo  = 1'b0;
         end else begin
            valid_now = ((ch_d0 | ch_d1) != '0);
            together  = !valid_now || ((ch_d0 ^ ch_d1) == '1);
            check("rail_exclusive", ch_d0 & ch_d1, 0);
            check("rails_together", together, 1);
            if (valid_now && !prev_valid) begin
               check("e_hi_before_data", seen_e_hi, 1);
               check("token_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  w  = exp_q.pop_front();
                  wn = ~w;
                  check("rail_d1_word", ch_d1, w);
                  check("rail_d0_word", ch_d0, wn);
               end
               seen_e_lo = 1'b0;
            end
            if (!valid_now && prev_valid) begin
               check("e_lo_before_neutral", seen_e_lo, 1);
               exp_done  = exp_done + 16'd1;
               seen_e_hi = 1'b0;
            end
            if (valid_now && !ch_e)  seen_e_lo = 1'b1;
            if (!valid_now && ch_e)  seen_e_hi = 1'b1;
            tok_exp = exp_done + tok_adj;
            check("tokens_sent", tokens_sent, tok_exp);
            if (in_valid && in_ready) exp_q.push_back(in_data);
            prev_valid = valid_now;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push_word(input logic [W-1:0] w);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < 800) begin
         @(negedge clk);
         n++;
         done = !busy && (count == 0) && (ch_d0 == '0) && (ch_d1 == '0) && ch_e
                && (exp_q.size() == 0);
      end
      check({tag, "_drained"}, done, 1);
   endtask

   task automatic wait_rails_valid(input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = ((ch_d0 | ch_d1) != '0);
      end
      check({tag, "_rails_valid"}, seen, 1);
   endtask

   initial begin
      int hi;
      int lo;
      int n;
      logic [W-1:0] words [4];

      // Reset with producer and sink both active.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = W'($urandom);
      repeat (3) @(negedge clk);
      check("rst_d0", ch_d0, 0);
      check("rst_d1", ch_d1, 0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_tokens", tokens_sent, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      sink_rst = 1'b0;
      @(negedge clk);
      check("rel_ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("rel_ready_after_edge", in_ready, 1);

      // Single token, sink answers a few cycles after data.
      sink_delay = 3;
      push_word(4'b0001);
      drain("single");
      check("single_tokens", tokens_sent, 1);
      check("single_count", count, 0);

      // Multi-bit word goes valid on all rails in one edge.
      push_word(4'b1010);
      wait_rails_valid("w1010");
      check("w1010_d1", ch_d1, 4'b1010);
      check("w1010_d0", ch_d0, 4'b0101);
      drain("w1010");
      check("w1010_tokens", tokens_sent, 2);

      // Source loop 0,1,1,0 with a responsive sink.
      sink_delay = 1;
      push_word(4'h0);
      push_word(4'hF);
      push_word(4'hF);
      push_word(4'h0);
      drain("loop");
      check("loop_tokens", tokens_sent, 6);

      // FIFO full with the sink holding enable low.
      hold_lo    = 1'b1;
      sink_delay = 0;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 4; i++) words[i] = W'($urandom);
      for (int i = 0; i < 4; i++) push_word(words[i]);
      @(negedge clk);
      check("full_count", count, 4);
      check("full_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 4'h9;
      repeat (3) @(negedge clk);
      check("full_ready_held", in_ready, 0);
      check("full_count_held", count, 4);
      check("full_rails_neutral", ch_d0 | ch_d1, 0);
      check("full_not_busy", busy, 0);
      hold_lo = 1'b0;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("full_fifth_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain("full");
      check("full_tokens", tokens_sent, 11);

      // Push and pop on the same edge at count 2.
      hold_lo = 1'b1;
      repeat (4) @(posedge clk);
      push_word(4'h3);
      push_word(4'hC);
      @(negedge clk);
      check("simul_count_before", count, 2);
      @(posedge clk); #1;
      hold_lo = 1'b0;
      repeat (S) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 4'h6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("simul_count_after", count, 2);
      check("simul_busy", busy, 1);
      drain("simul");
      check("simul_tokens", tokens_sent, 14);

      // Minimum handshake length and back-to-back spacing with an instant sink.
      hold_lo = 1'b1;
      repeat (4) @(posedge clk);
      push_word(4'h5);
      push_word(4'hA);
      hold_lo = 1'b0;
      n = 0;
      while (!busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      hi = 0;
      while (busy && hi < 60) begin
         @(negedge clk);
         hi++;
      end
      lo = 0;
      while (!busy && lo < 60) begin
         @(negedge clk);
         lo++;
      end
      check("b2b_first_len", hi, 4 + 2 * S);
      check("b2b_idle_gap", lo, 1);
      hi = 0;
      while (busy && hi < 60) begin
         @(negedge clk);
         hi++;
      end
      check("b2b_second_len", hi, 4 + 2 * S);
      drain("b2b");
      check("b2b_tokens", tokens_sent, 16);

      // Random words, gaps and sink response times.
      for (int i = 0; i < 16; i++) begin
         sink_delay = $urandom_range(0, 3);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         push_word(W'($urandom));
      end
      drain("random");
      check("random_tokens", tokens_sent, 32);

      // Reset while the sink still holds enable high over valid rails.
      sink_delay = 30;
      push_word(4'b0110);
      wait_rails_valid("midrst");
      repeat (2) @(posedge clk);
      #3;
      rst_n    = 1'b0;
      sink_rst = 1'b1;
      tok_adj  = '0;
      #1;
      check("midrst_d0", ch_d0, 0);
      check("midrst_d1", ch_d1, 0);
      check("midrst_tokens", tokens_sent, 0);
      check("midrst_busy", busy, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      sink_rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_idle_after", busy, 0);
      check("midrst_tokens_after", tokens_sent, 0);
      check("midrst_count_after", count, 0);

      // Counter wrap from 65535.
      sink_delay = 1;
      @(posedge clk); #1;
      force dut.token_cnt = 16'hFFFF;
      tok_adj = 16'hFFFF - exp_done;
      #2;
      release dut.token_cnt;
      @(negedge clk);
      check("wrap_preset", tokens_sent, 16'hFFFF);
      push_word(4'h7);
      drain("wrap");
      check("wrap_tokens", tokens_sent, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
